// File: rtl/power_pkg.sv
// Shared types and defaults for the power-switch sequencer.
package power_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 4;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    REQ    = 3'd1,
    START  = 3'd2,
    SETTLE = 3'd3,
    ON     = 3'd4,
    STOP   = 3'd5
  } power_state_t;

  // Registered output bundle of one stage.
  typedef struct packed {
    logic parent_request;
    logic switch_enb;
    logic child_ready;
    logic child_silent;
    logic child_starting;
    logic child_stopping;
  } power_out_t;

  // Moore decode of the state into the stage outputs.
  function automatic power_out_t decode_state(input power_state_t s);
    power_out_t o;
    o.parent_request = (s != OFF);
    o.switch_enb     = (s == START) || (s == SETTLE) || (s == ON);
    o.child_ready    = (s == ON);
    o.child_silent   = (s == OFF);
    o.child_starting = (s == REQ) || (s == START) || (s == SETTLE);
    o.child_stopping = (s == STOP);
    return o;
  endfunction

endpackage

// File: rtl/power_module_switch_if.sv
// Handshake bundle of one power stage: parent side, child side and the switch.
interface power_module_switch_if;

  logic parent_request;
  logic parent_ready;
  logic parent_silent;
  logic parent_starting;
  logic parent_stopping;
  logic child_request;
  logic child_ready;
  logic child_silent;
  logic child_starting;
  logic child_stopping;
  logic switch_enb;
  logic switch_ack;

  // Environment / neighbouring stages view.
  modport master (
    input  parent_request, child_ready, child_silent, child_starting, child_stopping, switch_enb,
    output parent_ready, parent_silent, parent_starting, parent_stopping, child_request, switch_ack
  );

  // Sequencer view.
  modport slave (
    output parent_request, child_ready, child_silent, child_starting, child_stopping, switch_enb,
    input  parent_ready, parent_silent, parent_starting, parent_stopping, child_request, switch_ack
  );

endinterface

// File: rtl/power_ack_sync.sv
// Multi-flop synchronizer for the asynchronous switch acknowledge.
module power_ack_sync
  import power_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic async_reset,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw acknowledge through the synchronizer chain.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/power_module_switch.sv
// Per-domain power-switch sequencer; stages chain root -> leaf through the bus interface.
module power_module_switch
  import power_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input logic                  clock,
  input logic                  async_reset,
  power_module_switch_if.slave bus
);

  localparam power_out_t OUT_RESET = '{
    parent_request: 1'b0,
    switch_enb:     1'b0,
    child_ready:    1'b0,
    child_silent:   1'b1,
    child_starting: 1'b0,
    child_stopping: 1'b0
  };

  power_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  power_out_t       out_q;
  logic             ack_s;
  logic             parent_ok;

  power_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock       (clock),
    .async_reset (async_reset),
    .async_i     (bus.switch_ack),
    .sync_o      (ack_s)
  );

  assign parent_ok = bus.parent_ready & ~bus.parent_silent &
                     ~bus.parent_starting & ~bus.parent_stopping;

  // Next-state and settle counter; switch transitions always run to completion.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      OFF: begin
        if (bus.child_request) state_d = REQ;
      end
      REQ: begin
        if (!bus.child_request) state_d = OFF;
        else if (parent_ok)     state_d = START;
      end
      START: begin
        if (!parent_ok) begin
          state_d = STOP;
        end else if (ack_s) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = ON;
          end else begin
            state_d = SETTLE;
            count_d = CNT_W'(SETTLE_CYCLES);
          end
        end
      end
      SETTLE: begin
        // Dwell exactly SETTLE_CYCLES clocks: leave when the count reaches zero.
        if (!parent_ok) begin
          state_d = STOP;
        end else begin
          count_d = count_q - CNT_W'(1);
          if (count_q <= CNT_W'(1)) state_d = ON;
        end
      end
      ON: begin
        if (!parent_ok || !bus.child_request) state_d = STOP;
      end
      STOP: begin
        if (!ack_s) state_d = OFF;
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // State, counter and registered output decode.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q <= OFF;
      count_q <= '0;
      out_q   <= OUT_RESET;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= decode_state(state_d);
    end
  end

  assign bus.parent_request = out_q.parent_request;
  assign bus.switch_enb     = out_q.switch_enb;
  assign bus.child_ready    = out_q.child_ready;
  assign bus.child_silent   = out_q.child_silent;
  assign bus.child_starting = out_q.child_starting;
  assign bus.child_stopping = out_q.child_stopping;

endmodule

// File: tb/tb_power_module_switch.sv
// Directed bench: single sequencer with a 3-clock switch model, plus a six-stage chain.
module tb_power_module_switch;

  localparam int unsigned N_STAGES = 6;
  localparam int          MIN_ENB  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  logic leaf_req = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #10 clk = ~clk;

  // ---------------- single instance ----------------
  power_module_switch_if dut_if ();

  power_module_switch u_dut (
    .clock       (clk),
    .async_reset (rst),
    .bus         (dut_if)
  );

  // Switch model: acknowledge follows enable three clocks later.
  logic [2:0] ack_sh;
  always @(posedge clk or posedge rst) begin
    if (rst) ack_sh <= '0;
    else     ack_sh <= {ack_sh[1:0], dut_if.switch_enb};
  end
  assign dut_if.switch_ack = ack_sh[2];

  // ---------------- six-stage chain ----------------
  power_module_switch_if cif [N_STAGES] ();
  logic [N_STAGES-1:0] ch_enb;
  logic [N_STAGES-1:0] ch_ack_q;
  logic                leaf_ready;
  logic                root_silent;

  // Each stage's switch acknowledges its own enable one clock later.
  always @(posedge clk or posedge rst) begin
    if (rst) ch_ack_q <= '0;
    else     ch_ack_q <= ch_enb;
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_chain
    power_module_switch u_stage (
      .clock       (clk),
      .async_reset (rst),
      .bus         (cif[k])
    );
    assign ch_enb[k]         = cif[k].switch_enb;
    assign cif[k].switch_ack = ch_ack_q[k];
    if (k == 0) begin : g_root
      assign cif[k].parent_ready    = 1'b1;
      assign cif[k].parent_silent   = 1'b0;
      assign cif[k].parent_starting = 1'b0;
      assign cif[k].parent_stopping = 1'b0;
    end else begin : g_mid
      assign cif[k].parent_ready    = cif[k-1].child_ready;
      assign cif[k].parent_silent   = cif[k-1].child_silent;
      assign cif[k].parent_starting = cif[k-1].child_starting;
      assign cif[k].parent_stopping = cif[k-1].child_stopping;
    end
    if (k == N_STAGES - 1) begin : g_leaf
      assign cif[k].child_request = leaf_req;
    end else begin : g_inner
      assign cif[k].child_request = cif[k+1].parent_request;
    end
  end

  assign leaf_ready  = cif[N_STAGES-1].child_ready;
  assign root_silent = cif[0].child_silent;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {dut_if.parent_request, dut_if.switch_enb, dut_if.child_ready,
            dut_if.child_silent, dut_if.child_starting, dut_if.child_stopping};
  endfunction

  // Output vector order: {parent_request, switch_enb, ready, silent, starting, stopping}.
  task automatic chk_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = outs();
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps until child_ready; returns 41 if it never arrives.
  task automatic wait_ready(output int steps);
    steps = 41;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (dut_if.child_ready) begin
        steps = i;
        break;
      end
    end
  endtask

  task automatic wait_silent(output int steps);
    steps = 41;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (dut_if.child_silent) begin
        steps = i;
        break;
      end
    end
  endtask

  // Enable pulse width monitor: no high pulse shorter than the START dwell.
  int hi_len = 0;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      hi_len = 0;
    end else if (dut_if.switch_enb) begin
      hi_len++;
    end else begin
      if (hi_len > 0) begin
        n_chk++;
        assert (hi_len >= MIN_ENB) else begin
          n_err++;
          $error("FAIL enb_pulse_width observed=%0d expected>=%0d", hi_len, MIN_ENB);
        end
      end
      hi_len = 0;
    end
  end

  localparam logic [5:0] O_OFF   = 6'b000100;
  localparam logic [5:0] O_REQ   = 6'b100010;
  localparam logic [5:0] O_START = 6'b110010;
  localparam logic [5:0] O_ON    = 6'b111000;
  localparam logic [5:0] O_STOP  = 6'b100001;

  int lat;
  int rise_c [N_STAGES];
  int fall_c [N_STAGES];

  initial begin
    dut_if.child_request   = 1'b1;
    dut_if.parent_ready    = 1'b1;
    dut_if.parent_silent   = 1'b0;
    dut_if.parent_starting = 1'b0;
    dut_if.parent_stopping = 1'b0;

    // Reset with request held high.
    repeat (3) step();
    chk_out("reset_hold", O_OFF);
    step();
    chk_out("reset_hold2", O_OFF);

    // Power-up timing.
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    chk_out("req_first", O_REQ);
    step();
    chk_out("start_enb", O_START);
    repeat (9) step();
    chk_out("settle_not_ready", O_START);
    step();
    chk_out("on_ready", O_ON);

    // Release.
    dut_if.child_request = 1'b0;
    step();
    chk_out("stop_enb_low", O_STOP);
    repeat (5) step();
    chk_out("stop_wait_ack", O_STOP);
    step();
    chk_out("off_silent", O_OFF);

    // Second power-up from idle.
    dut_if.child_request = 1'b1;
    wait_ready(lat);
    chk_int("lat_rampup", lat, 12);

    // One-clock request gap while ON.
    dut_if.child_request = 1'b0;
    step();
    chk_out("gap_stop", O_STOP);
    dut_if.child_request = 1'b1;
    repeat (5) step();
    chk_out("gap_stop_hold", O_STOP);
    step();
    chk_out("gap_off", O_OFF);
    step();
    chk_out("gap_req", O_REQ);
    step();
    chk_out("gap_restart", O_START);
    wait_ready(lat);
    chk_int("lat_after_gap", lat, 10);

    // Parent not ready: park in REQ.
    dut_if.child_request = 1'b0;
    wait_silent(lat);
    chk_int("lat_release", lat, 7);
    dut_if.parent_ready  = 1'b0;
    dut_if.child_request = 1'b1;
    repeat (8) step();
    chk_out("parent_wait", O_REQ);
    dut_if.parent_ready = 1'b1;
    wait_ready(lat);
    chk_int("lat_parent_go", lat, 11);

    // Parent lost while ON: forced power-down, then re-request.
    dut_if.parent_ready = 1'b0;
    step();
    chk_out("parent_lost", O_STOP);
    repeat (5) step();
    chk_out("parent_lost_hold", O_STOP);
    step();
    chk_out("parent_lost_off", O_OFF);
    step();
    chk_out("parent_lost_req", O_REQ);
    repeat (3) step();
    chk_out("parent_lost_park", O_REQ);
    dut_if.parent_ready = 1'b1;
    wait_ready(lat);
    chk_int("lat_parent_back", lat, 11);

    // Parent stopping also revokes parent_ok.
    dut_if.parent_stopping = 1'b1;
    step();
    chk_out("parent_stopping", O_STOP);
    dut_if.parent_stopping = 1'b0;
    dut_if.child_request   = 1'b0;
    wait_silent(lat);
    chk_int("lat_forced_off", lat, 6);

    // Request drop during SETTLE completes to ON, then leaves.
    dut_if.child_request = 1'b1;
    repeat (8) step();
    chk_out("settle_entry", O_START);
    dut_if.child_request = 1'b0;
    repeat (3) step();
    chk_out("settle_no_abort", O_START);
    step();
    chk_out("settle_drop_on", O_ON);
    step();
    chk_out("settle_drop_leave", O_STOP);
    repeat (6) step();
    chk_out("settle_drop_off", O_OFF);

    // Asynchronous reset in the middle of a power-up.
    dut_if.child_request = 1'b1;
    repeat (5) step();
    chk_out("pre_reset_start", O_START);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("async_reset", O_OFF);
    dut_if.child_request = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_out("post_reset_idle", O_OFF);

    // Chain: enables rise root-first.
    for (int k = 0; k < N_STAGES; k++) begin
      rise_c[k] = -1;
      fall_c[k] = -1;
    end
    leaf_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int k = 0; k < N_STAGES; k++)
        if (rise_c[k] < 0 && ch_enb[k]) rise_c[k] = c;
      if (leaf_ready) break;
    end
    chk_int("chain_leaf_ready", int'(leaf_ready), 1);
    for (int k = 0; k < N_STAGES - 1; k++)
      chk_int($sformatf("chain_rise_order_%0d", k),
              int'(rise_c[k] >= 0 && rise_c[k+1] > rise_c[k]), 1);

    // Chain: enables fall leaf-first.
    leaf_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int k = 0; k < N_STAGES; k++)
        if (fall_c[k] < 0 && !ch_enb[k]) fall_c[k] = c;
      if (root_silent) break;
    end
    chk_int("chain_root_silent", int'(root_silent), 1);
    for (int k = 0; k < N_STAGES - 1; k++)
      chk_int($sformatf("chain_fall_order_%0d", k),
              int'(fall_c[k+1] >= 0 && fall_c[k] > fall_c[k+1]), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
